// File: rtl/cyx_demux_pkg.sv
// Shared types for the 1:2 stream demux: FSM state, beat layout and buffer depth.
package cyx_demux_pkg;

  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } demux_state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W:0]   data;
  } beat_t;

endpackage

// File: rtl/cyx_skid_buf.sv
// Two-entry registered FIFO holding {last, data} beats for one demux output port.
module cyx_skid_buf
  import cyx_demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             push_last_i,
  input  logic [WIDTH:0]   push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             last_o,
  output logic [WIDTH:0]   data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH:0]   data_q [BUF_DEPTH];
  logic             last_q [BUF_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop;

  // The top never pushes into a full buffer; the guard keeps the FIFO safe regardless.
  assign push_ok = push_i && (count_q != CNT_W'(BUF_DEPTH));
  assign pop     = valid_o && ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cyx_stream_demux.sv
// Routes a valid/ready packet stream to one of two buffered outputs; the
// destination is latched on the first beat and held until the last beat.
module cyx_stream_demux
  import cyx_demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [WIDTH:0] in_data_i,
  input  logic           in_seln_i,
  input  logic           in_last_i,
  output logic           out0_valid_o,
  input  logic           out0_ready_i,
  output logic [WIDTH:0] out0_data_o,
  output logic           out0_last_o,
  output logic           out1_valid_o,
  input  logic           out1_ready_i,
  output logic [WIDTH:0] out1_data_o,
  output logic           out1_last_o,
  output logic           busy_o,
  output logic           cur_sel_o
);

  demux_state_e     state_q, state_d;
  logic             cur_sel_q, cur_sel_d;
  logic             sel;
  logic             accept;
  logic [CNT_W-1:0] count0, count1;
  logic             push0, push1;

  assign sel = (state_q == IDLE) ? in_seln_i : cur_sel_q;

  // Ready looks only at registered occupancy, so a full buffer stays closed even
  // in a cycle where the consumer is draining it.
  assign in_ready_o = sel ? (count1 < CNT_W'(BUF_DEPTH))
                          : (count0 < CNT_W'(BUF_DEPTH));
  assign accept     = in_valid_i && in_ready_o;
  assign push0      = accept && !sel;
  assign push1      = accept &&  sel;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          cur_sel_d = in_seln_i;
          if (!in_last_i) begin
            state_d = IN_PKT;
          end
        end
        IN_PKT: begin
          if (in_last_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign busy_o    = (state_q == IN_PKT);
  assign cur_sel_o = cur_sel_q;

  cyx_skid_buf #(.WIDTH(WIDTH)) u_buf0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push0),
    .push_last_i (in_last_i),
    .push_data_i (in_data_i),
    .ready_i     (out0_ready_i),
    .valid_o     (out0_valid_o),
    .last_o      (out0_last_o),
    .data_o      (out0_data_o),
    .count_o     (count0)
  );

  cyx_skid_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push1),
    .push_last_i (in_last_i),
    .push_data_i (in_data_i),
    .ready_i     (out1_ready_i),
    .valid_o     (out1_valid_o),
    .last_o      (out1_last_o),
    .data_o      (out1_data_o),
    .count_o     (count1)
  );

endmodule

// File: tb/tb_cyx_stream_demux.sv
// Directed self-checking bench for cyx_stream_demux: one task per scenario.
module tb_cyx_stream_demux;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   in_data;
  logic         in_seln;
  logic         in_last;
  logic         out0_valid, out0_ready, out0_last;
  logic [W:0]   out0_data;
  logic         out1_valid, out1_ready, out1_last;
  logic [W:0]   out1_data;
  logic         busy;
  logic         cur_sel;

  int errors = 0;
  int checks = 0;

  cyx_stream_demux #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_seln_i    (in_seln),
    .in_last_i    (in_last),
    .out0_valid_o (out0_valid),
    .out0_ready_i (out0_ready),
    .out0_data_o  (out0_data),
    .out0_last_o  (out0_last),
    .out1_valid_o (out1_valid),
    .out1_ready_i (out1_ready),
    .out1_data_o  (out1_data),
    .out1_last_o  (out1_last),
    .busy_o       (busy),
    .cur_sel_o    (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W:0] d, input logic s, input logic l);
    in_valid = v;
    in_data  = d;
    in_seln  = s;
    in_last  = l;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", out0_valid, out1_valid); end
    checks++; if (busy !== 1'b0 || cur_sel !== 1'b0) begin errors++; $display("FAIL reset_state busy=%b cur_sel=%b exp=0/0", busy, cur_sel); end
    checks++; if (out0_data !== '0 || out0_last !== 1'b0) begin errors++; $display("FAIL reset_out0 data=%h last=%b exp=0/0", out0_data, out0_last); end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single_beat();
    drive(1'b1, 33'h0_0000_00AA, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", in_ready); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    $display("single beat data=%h port0", 33'h0AA);
    checks++; if (out0_valid !== 1'b1 || out0_data !== 33'h0AA || out0_last !== 1'b1) begin
      errors++; $display("FAIL single_out0 valid=%b data=%h last=%b exp=1/0aa/1", out0_valid, out0_data, out0_last); end
    checks++; if (out1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_side out1_valid=%b busy=%b exp=0/0", out1_valid, busy); end
    out0_ready = 1'b1;
    tick();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL single_drain out0_valid=%b exp=0", out0_valid); end
    out0_ready = 1'b0;
  endtask

  task automatic test_packet_lock();
    logic [W:0] vals [4];
    logic       selns [4];
    vals[0] = 33'h11; vals[1] = 33'h22; vals[2] = 33'h33; vals[3] = 33'h44;
    selns[0] = 1'b1;  selns[1] = 1'b0;  selns[2] = 1'b1;  selns[3] = 1'b0;
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], selns[i], (i == 3));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lock_ready beat=%0d got=%b exp=1", i, in_ready); end
      tick();
      $display("lock beat %0d data=%h seln=%b", i, vals[i], selns[i]);
      checks++; if (out1_valid !== 1'b1 || out1_data !== vals[i] || out1_last !== (i == 3)) begin
        errors++; $display("FAIL lock_out1 beat=%0d valid=%b data=%h last=%b exp=1/%h/%b", i, out1_valid, out1_data, out1_last, vals[i], (i == 3)); end
      checks++; if (out0_valid !== 1'b0 || busy !== (i < 3) || cur_sel !== 1'b1) begin
        errors++; $display("FAIL lock_state beat=%0d out0_valid=%b busy=%b cur_sel=%b exp=0/%b/1", i, out0_valid, busy, cur_sel, (i < 3)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL lock_drain out1_valid=%b exp=0", out1_valid); end
    out1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    drive(1'b1, 33'h1, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, 33'h2, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got=%b exp=1", in_ready); end
    tick();
    drive(1'b1, 33'h3, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got=%b exp=0", in_ready); end
    tick();
    checks++; if (out0_data !== 33'h1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold data=%h busy=%b in_ready=%b exp=1/1/0", out0_data, busy, in_ready); end
    out0_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_passthru in_ready=%b exp=0", in_ready); end
    tick();
    $display("bp drained data=%h", 33'h1);
    checks++; if (out0_data !== 33'h2 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 data=%h in_ready=%b exp=2/1", out0_data, in_ready); end
    tick();
    $display("bp drained data=%h, accepted data=%h", 33'h2, 33'h3);
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (out0_valid !== 1'b1 || out0_data !== 33'h3 || out0_last !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_pop2 valid=%b data=%h last=%b busy=%b exp=1/3/1/0", out0_valid, out0_data, out0_last, busy); end
    tick();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL bp_empty out0_valid=%b exp=0", out0_valid); end
    out0_ready = 1'b0;
  endtask

  task automatic test_port_stall();
    out0_ready = 1'b0;
    drive(1'b1, 33'h5, 1'b0, 1'b1);
    tick();
    drive(1'b1, 33'h6, 1'b0, 1'b1);
    tick();
    drive(1'b1, 33'h7, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full0 in_ready=%b exp=0", in_ready); end
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 33'h71 + 33'(i), 1'b1, (i == 2));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 beat=%0d got=%b exp=1", i, in_ready); end
      tick();
      $display("stall beat %0d data=%h port1", i, 33'h71 + 33'(i));
      checks++; if (out1_valid !== 1'b1 || out1_data !== 33'h71 + 33'(i) || out0_data !== 33'h5 || out0_valid !== 1'b1) begin
        errors++; $display("FAIL stall_flow beat=%0d out1=%b/%h out0=%b/%h exp=1/%h 1/5", i, out1_valid, out1_data, out0_valid, out0_data, 33'h71 + 33'(i)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    out1_ready = 1'b0;
    out0_ready = 1'b1;
    tick();
    checks++; if (out0_data !== 33'h6 || out0_valid !== 1'b1) begin errors++; $display("FAIL stall_drain0 data=%h valid=%b exp=6/1", out0_data, out0_valid); end
    tick();
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b1) begin errors++; $display("FAIL stall_empty valid0=%b valid1=%b exp=0/1", out0_valid, out1_valid); end
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out1_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 33'h1000 + 33'(i), (i % 3 != 1), (i == 99));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, in_ready); end
      tick();
      $display("b2b beat %0d data=%h", i, 33'h1000 + 33'(i));
      checks++; if (out1_valid !== 1'b1 || out1_data !== 33'h1000 + 33'(i) || out1_last !== (i == 99) || out0_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_out1 beat=%0d data=%h last=%b out0_valid=%b exp=%h/%b/0", i, out1_data, out1_last, out0_valid, 33'h1000 + 33'(i), (i == 99)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    checks++; if (out1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end valid=%b busy=%b exp=0/0", out1_valid, busy); end
    out1_ready = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    out0_ready = 1'b0;
    drive(1'b1, 33'hA1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 33'hA2, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || out0_valid !== 1'b1) begin errors++; $display("FAIL mid_before busy=%b valid=%b exp=1/1", busy, out0_valid); end
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-packet");
    checks++; if (out0_valid !== 1'b0 || busy !== 1'b0 || cur_sel !== 1'b0 || out0_data !== '0) begin
      errors++; $display("FAIL mid_reset valid=%b busy=%b cur_sel=%b data=%h exp=0/0/0/0", out0_valid, busy, cur_sel, out0_data); end
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 33'hB1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 33'hB2, 1'b0, 1'b1);
    checks++; if (out1_data !== 33'hB1 || out1_valid !== 1'b1 || out0_valid !== 1'b0 || cur_sel !== 1'b1) begin
      errors++; $display("FAIL mid_restart1 out1=%b/%h out0_valid=%b cur_sel=%b exp=1/b1/0/1", out1_valid, out1_data, out0_valid, cur_sel); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    out1_ready = 1'b1;
    tick();
    $display("restart packet beats b1,b2 port1");
    checks++; if (out1_data !== 33'hB2 || out1_last !== 1'b1 || out1_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_restart2 data=%h last=%b valid=%b busy=%b exp=b2/1/1/0", out1_data, out1_last, out1_valid, busy); end
    tick();
    out1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_port_stall();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
